// File: rtl/pair_motion_estimator.sv
// -----------------------------------------------------------------------------
// pair_motion_estimator
//
// Reduces the matched-feature pair stream of one frame to a single global
// inter-frame motion vector: the mean displacement (current - previous).
// Pairs accumulate while the previous frame's mean is still being divided.
// At end of frame the sums are handed to two parallel restoring dividers
// (X and Y), and the signed quotients are published with a one-cycle
// motion_valid pulse.
//
// Optional build macro:
//   MOTION_IIR_EN - when defined, the published vector is first-order
//                   smoothed: out = prev_out + ((mean - prev_out) >>> IIR_SHIFT).
//                   Frames with no pairs leave the vector unchanged.
//
// Ports:
//   clk                : clock
//   reset              : asynchronous reset, active low
//   current_feature_X/Y: current-frame feature coordinate
//   prev_feature_X/Y   : matched previous-frame feature coordinate
//   pair_valid         : coordinates valid this cycle
//   pair_done          : one-cycle end-of-frame marker (a same-cycle pair
//                        belongs to the closing frame)
//   motion_dx/dy       : signed mean displacement, held between pulses
//   motion_valid       : one-cycle pulse when motion_dx/dy/match_count update
//   match_count        : number of pairs behind the emitted vector
//   busy               : high while a division is in flight
//   overrun            : one-cycle pulse when a frame result is dropped
// -----------------------------------------------------------------------------
module pair_motion_estimator #(
    parameter int HORIZEN   = 320,
    parameter int VERTICAL  = 240,
    parameter int MAX_PAIRS = 100,
    parameter int X_WIDTH   = $clog2(HORIZEN),
    parameter int Y_WIDTH   = $clog2(VERTICAL),
    parameter int CNT_WIDTH = $clog2(MAX_PAIRS + 1),
    parameter int ACC_WIDTH = X_WIDTH + 1 + CNT_WIDTH,
    parameter int IIR_SHIFT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [X_WIDTH-1:0]          current_feature_X,
    input  logic [Y_WIDTH-1:0]          current_feature_Y,
    input  logic [X_WIDTH-1:0]          prev_feature_X,
    input  logic [Y_WIDTH-1:0]          prev_feature_Y,
    input  logic                        pair_valid,
    input  logic                        pair_done,
    output logic signed [X_WIDTH:0]     motion_dx,
    output logic signed [Y_WIDTH:0]     motion_dy,
    output logic                        motion_valid,
    output logic [CNT_WIDTH-1:0]        match_count,
    output logic                        busy,
    output logic                        overrun
);

    localparam int STEP_W = $clog2(ACC_WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        OUTPUT = 2'd2
    } state_t;

    // Magnitude of a signed accumulator.
    function automatic logic [ACC_WIDTH-1:0] magnitude(input logic signed [ACC_WIDTH-1:0] v);
        return v[ACC_WIDTH-1] ? ACC_WIDTH'(-v) : ACC_WIDTH'(v);
    endfunction

    // Re-apply the sign to an unsigned quotient; truncation toward zero
    // falls out of dividing magnitudes. An empty frame forces zero.
    function automatic logic signed [ACC_WIDTH-1:0] apply_sign(
        input logic [ACC_WIDTH-1:0] quo,
        input logic                 neg,
        input logic                 empty
    );
        if (empty) begin
            return '0;
        end
        return neg ? -$signed(quo) : $signed(quo);
    endfunction

    // First-order smoothing toward the new mean.
    function automatic logic signed [ACC_WIDTH-1:0] iir_step(
        input logic signed [ACC_WIDTH-1:0] prev,
        input logic signed [ACC_WIDTH-1:0] mean
    );
        logic signed [ACC_WIDTH-1:0] diff;
        diff = mean - prev;
        return prev + (diff >>> IIR_SHIFT);
    endfunction

    // One restoring-division step. The dividend shifts out of the MSB of
    // quo while quotient bits shift in at the LSB; after ACC_WIDTH steps
    // quo holds the full quotient. The remainder is always below the
    // divisor, so CNT_WIDTH bits suffice (a zero divisor only produces
    // garbage that is discarded).
    function automatic void div_step(
        input  logic [CNT_WIDTH-1:0] rem,
        input  logic [ACC_WIDTH-1:0] quo,
        input  logic [CNT_WIDTH-1:0] dvs,
        output logic [CNT_WIDTH-1:0] rem_n,
        output logic [ACC_WIDTH-1:0] quo_n
    );
        logic [CNT_WIDTH:0] trial;
        trial = {rem, quo[ACC_WIDTH-1]};
        if (trial >= {1'b0, dvs}) begin
            rem_n = CNT_WIDTH'(trial - {1'b0, dvs});
            quo_n = {quo[ACC_WIDTH-2:0], 1'b1};
        end else begin
            rem_n = trial[CNT_WIDTH-1:0];
            quo_n = {quo[ACC_WIDTH-2:0], 1'b0};
        end
    endfunction

    state_t                       state_q;
    logic signed [ACC_WIDTH-1:0]  sum_dx_q, sum_dx_d, sum_dx_cl;
    logic signed [ACC_WIDTH-1:0]  sum_dy_q, sum_dy_d, sum_dy_cl;
    logic [CNT_WIDTH-1:0]         cnt_q, cnt_d, cnt_cl;
    logic [ACC_WIDTH-1:0]         quo_x_q, quo_x_d;
    logic [ACC_WIDTH-1:0]         quo_y_q, quo_y_d;
    logic [CNT_WIDTH-1:0]         rem_x_q, rem_x_d;
    logic [CNT_WIDTH-1:0]         rem_y_q, rem_y_d;
    logic                         neg_x_q, neg_y_q;
    logic [CNT_WIDTH-1:0]         div_cnt_q;
    logic [STEP_W-1:0]            step_q;
    logic signed [X_WIDTH:0]      motion_dx_q;
    logic signed [Y_WIDTH:0]      motion_dy_q;
    logic                         motion_valid_q;
    logic [CNT_WIDTH-1:0]         match_count_q;
    logic                         busy_q;
    logic                         overrun_q;

    logic signed [X_WIDTH:0]      pair_dx;
    logic signed [Y_WIDTH:0]      pair_dy;
    logic                         take;
    logic signed [ACC_WIDTH-1:0]  mean_x, mean_y;
    logic signed [ACC_WIDTH-1:0]  out_x, out_y;

    assign pair_dx = $signed({1'b0, current_feature_X}) - $signed({1'b0, prev_feature_X});
    assign pair_dy = $signed({1'b0, current_feature_Y}) - $signed({1'b0, prev_feature_Y});

    // Accumulation runs regardless of divider state. *_cl is the frame
    // total including any same-cycle pair; pair_done always restarts the
    // accumulators so the closing pair is never carried forward.
    always_comb begin
        take      = pair_valid && (cnt_q != CNT_WIDTH'(MAX_PAIRS));
        sum_dx_cl = sum_dx_q;
        sum_dy_cl = sum_dy_q;
        cnt_cl    = cnt_q;
        if (take) begin
            sum_dx_cl = sum_dx_q + ACC_WIDTH'(pair_dx);
            sum_dy_cl = sum_dy_q + ACC_WIDTH'(pair_dy);
            cnt_cl    = cnt_q + CNT_WIDTH'(1);
        end
        sum_dx_d = pair_done ? '0 : sum_dx_cl;
        sum_dy_d = pair_done ? '0 : sum_dy_cl;
        cnt_d    = pair_done ? '0 : cnt_cl;
    end

    always_comb begin
        rem_x_d = '0;
        rem_y_d = '0;
        quo_x_d = '0;
        quo_y_d = '0;
        div_step(rem_x_q, quo_x_q, div_cnt_q, rem_x_d, quo_x_d);
        div_step(rem_y_q, quo_y_q, div_cnt_q, rem_y_d, quo_y_d);
    end

    always_comb begin
        mean_x = apply_sign(quo_x_q, neg_x_q, div_cnt_q == '0);
        mean_y = apply_sign(quo_y_q, neg_y_q, div_cnt_q == '0);
`ifdef MOTION_IIR_EN
        out_x = (div_cnt_q == '0) ? ACC_WIDTH'(motion_dx_q) : iir_step(ACC_WIDTH'(motion_dx_q), mean_x);
        out_y = (div_cnt_q == '0) ? ACC_WIDTH'(motion_dy_q) : iir_step(ACC_WIDTH'(motion_dy_q), mean_y);
`else
        out_x = mean_x;
        out_y = mean_y;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            sum_dx_q       <= '0;
            sum_dy_q       <= '0;
            cnt_q          <= '0;
            quo_x_q        <= '0;
            quo_y_q        <= '0;
            rem_x_q        <= '0;
            rem_y_q        <= '0;
            neg_x_q        <= 1'b0;
            neg_y_q        <= 1'b0;
            div_cnt_q      <= '0;
            step_q         <= '0;
            motion_dx_q    <= '0;
            motion_dy_q    <= '0;
            motion_valid_q <= 1'b0;
            match_count_q  <= '0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            sum_dx_q       <= sum_dx_d;
            sum_dy_q       <= sum_dy_d;
            cnt_q          <= cnt_d;
            motion_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pair_done) begin
                        quo_x_q   <= magnitude(sum_dx_cl);
                        quo_y_q   <= magnitude(sum_dy_cl);
                        neg_x_q   <= sum_dx_cl[ACC_WIDTH-1];
                        neg_y_q   <= sum_dy_cl[ACC_WIDTH-1];
                        div_cnt_q <= cnt_cl;
                        rem_x_q   <= '0;
                        rem_y_q   <= '0;
                        step_q    <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    // A frame closing now has nowhere to go; its sums were
                    // already cleared above.
                    overrun_q <= pair_done;
                    quo_x_q   <= quo_x_d;
                    quo_y_q   <= quo_y_d;
                    rem_x_q   <= rem_x_d;
                    rem_y_q   <= rem_y_d;
                    step_q    <= step_q + STEP_W'(1);
                    if (step_q == STEP_W'(ACC_WIDTH - 1)) begin
                        state_q <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    overrun_q      <= pair_done;
                    motion_dx_q    <= (X_WIDTH + 1)'(out_x);
                    motion_dy_q    <= (Y_WIDTH + 1)'(out_y);
                    match_count_q  <= div_cnt_q;
                    motion_valid_q <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign motion_dx    = motion_dx_q;
    assign motion_dy    = motion_dy_q;
    assign motion_valid = motion_valid_q;
    assign match_count  = match_count_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pair_motion_estimator.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for pair_motion_estimator (default build).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_pair_motion_estimator;

    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 7;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [XW-1:0]        cur_x = '0;
    logic [YW-1:0]        cur_y = '0;
    logic [XW-1:0]        prv_x = '0;
    logic [YW-1:0]        prv_y = '0;
    logic                 pair_valid = 1'b0;
    logic                 pair_done = 1'b0;
    logic signed [XW:0]   motion_dx;
    logic signed [YW:0]   motion_dy;
    logic                 motion_valid;
    logic [CW-1:0]        match_count;
    logic                 busy;
    logic                 overrun;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    pair_motion_estimator dut (
        .clk               (clk),
        .reset             (reset),
        .current_feature_X (cur_x),
        .current_feature_Y (cur_y),
        .prev_feature_X    (prv_x),
        .prev_feature_Y    (prv_y),
        .pair_valid        (pair_valid),
        .pair_done         (pair_done),
        .motion_dx         (motion_dx),
        .motion_dy         (motion_dy),
        .motion_valid      (motion_valid),
        .match_count       (match_count),
        .busy              (busy),
        .overrun           (overrun)
    );

    task automatic set_coords(input int cx, input int cy, input int px, input int py);
        cur_x = XW'(cx);
        cur_y = YW'(cy);
        prv_x = XW'(px);
        prv_y = YW'(py);
    endtask

    task automatic drive_pair(input int cx, input int cy, input int px, input int py);
        set_coords(cx, cy, px, py);
        pair_valid = 1'b1;
        @(posedge clk); #1;
        pair_valid = 1'b0;
    endtask

    // Pulse pair_done (optionally with a coincident pair), then watch 30 edges.
    task automatic close_frame(input bit with_pair, input int cx, input int cy,
                               input int px, input int py,
                               output int lat, output int busy_n,
                               output int pulses, output int ov_n);
        pair_done = 1'b1;
        if (with_pair) begin
            set_coords(cx, cy, px, py);
            pair_valid = 1'b1;
        end
        @(posedge clk); #1;
        pair_done  = 1'b0;
        pair_valid = 1'b0;
        busy_n = busy ? 1 : 0;
        lat    = -1;
        pulses = 0;
        ov_n   = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (motion_valid) begin
                pulses++;
                if (lat < 0) lat = k;
            end
            if (busy) busy_n++;
            if (overrun) ov_n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (int'(motion_dx) !== 0) begin n_fails++; $display("FAIL reset_dx: got %0d expected 0", motion_dx); end
        n_checks++; if (int'(motion_dy) !== 0) begin n_fails++; $display("FAIL reset_dy: got %0d expected 0", motion_dy); end
        n_checks++; if (motion_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b expected 0", motion_valid); end
        n_checks++; if (match_count !== '0) begin n_fails++; $display("FAIL reset_count: got %0d expected 0", match_count); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overrun !== 1'b0) begin n_fails++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat, busy_n, pulses, ov_n;
        repeat (3) drive_pair(104, 50, 100, 52);
        close_frame(1'b0, 0, 0, 0, 0, lat, busy_n, pulses, ov_n);
        n_checks++; if (lat !== 18) begin n_fails++; $display("FAIL basic_latency: valid %0d edges after pair_done edge, expected 18", lat); end
        n_checks++; if (busy_n !== 18) begin n_fails++; $display("FAIL basic_busy_cycles: got %0d expected 18", busy_n); end
        n_checks++; if (pulses !== 1) begin n_fails++; $display("FAIL basic_pulses: got %0d expected 1", pulses); end
        n_checks++; if (int'(motion_dx) !== 4) begin n_fails++; $display("FAIL basic_dx: got %0d expected 4", motion_dx); end
        n_checks++; if (int'(motion_dy) !== -2) begin n_fails++; $display("FAIL basic_dy: got %0d expected -2", motion_dy); end
        n_checks++; if (int'(match_count) !== 3) begin n_fails++; $display("FAIL basic_count: got %0d expected 3", match_count); end
        n_checks++; if (ov_n !== 0) begin n_fails++; $display("FAIL basic_overrun: got %0d pulses expected 0", ov_n); end
    endtask

    task automatic test_truncation();
        int lat, busy_n, pulses, ov_n;
        drive_pair(13, 20, 10, 20);
        drive_pair(14, 20, 10, 20);
        close_frame(1'b0, 0, 0, 0, 0, lat, busy_n, pulses, ov_n);
        n_checks++; if (int'(motion_dx) !== 3) begin n_fails++; $display("FAIL trunc_pos_dx: got %0d expected 3", motion_dx); end
        n_checks++; if (int'(motion_dy) !== 0) begin n_fails++; $display("FAIL trunc_pos_dy: got %0d expected 0", motion_dy); end
        drive_pair(10, 20, 13, 20);
        drive_pair(10, 20, 14, 20);
        close_frame(1'b0, 0, 0, 0, 0, lat, busy_n, pulses, ov_n);
        n_checks++; if (int'(motion_dx) !== -3) begin n_fails++; $display("FAIL trunc_neg_dx: got %0d expected -3", motion_dx); end
        n_checks++; if (int'(motion_dy) !== 0) begin n_fails++; $display("FAIL trunc_neg_dy: got %0d expected 0", motion_dy); end
        n_checks++; if (int'(match_count) !== 2) begin n_fails++; $display("FAIL trunc_count: got %0d expected 2", match_count); end
    endtask

    task automatic test_coincident();
        int lat, busy_n, pulses, ov_n;
        drive_pair(52, 40, 50, 40);
        drive_pair(52, 40, 50, 40);
        close_frame(1'b1, 55, 40, 50, 40, lat, busy_n, pulses, ov_n);
        n_checks++; if (int'(match_count) !== 3) begin n_fails++; $display("FAIL coincident_count: got %0d expected 3", match_count); end
        n_checks++; if (int'(motion_dx) !== 3) begin n_fails++; $display("FAIL coincident_dx: got %0d expected 3", motion_dx); end
    endtask

    task automatic test_empty();
        int lat, busy_n, pulses, ov_n;
        close_frame(1'b0, 0, 0, 0, 0, lat, busy_n, pulses, ov_n);
        n_checks++; if (pulses !== 1) begin n_fails++; $display("FAIL empty_pulses: got %0d expected 1", pulses); end
        n_checks++; if (int'(motion_dx) !== 0) begin n_fails++; $display("FAIL empty_dx: got %0d expected 0", motion_dx); end
        n_checks++; if (int'(motion_dy) !== 0) begin n_fails++; $display("FAIL empty_dy: got %0d expected 0", motion_dy); end
        n_checks++; if (int'(match_count) !== 0) begin n_fails++; $display("FAIL empty_count: got %0d expected 0", match_count); end
    endtask

    task automatic test_max_pairs();
        int lat, busy_n, pulses, ov_n;
        repeat (100) drive_pair(101, 101, 100, 100);
        // Pairs past the cap carry large displacements that would skew the mean.
        repeat (4) drive_pair(200, 150, 100, 100);
        close_frame(1'b1, 200, 150, 100, 100, lat, busy_n, pulses, ov_n);
        n_checks++; if (int'(match_count) !== 100) begin n_fails++; $display("FAIL max_count: got %0d expected 100", match_count); end
        n_checks++; if (int'(motion_dx) !== 1) begin n_fails++; $display("FAIL max_dx: got %0d expected 1", motion_dx); end
        n_checks++; if (int'(motion_dy) !== 1) begin n_fails++; $display("FAIL max_dy: got %0d expected 1", motion_dy); end
    endtask

    task automatic test_overrun();
        int lat, busy_n, pulses, ov_n, ov_at, v_at, v_n;
        int cap_dx, cap_dy, cap_cnt;
        ov_n = 0; ov_at = -1; v_at = -1; v_n = 0;
        cap_dx = 0; cap_dy = 0; cap_cnt = 0;
        drive_pair(108, 60, 100, 50);
        drive_pair(108, 60, 100, 50);
        pair_done = 1'b1;
        @(posedge clk); #1;
        pair_done = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            pair_valid = 1'b0;
            pair_done  = 1'b0;
            if (k == 1 || k == 2) begin set_coords(120, 50, 100, 50); pair_valid = 1'b1; end
            if (k == 5) pair_done = 1'b1;
            if (k == 6 || k == 7) begin set_coords(102, 49, 100, 50); pair_valid = 1'b1; end
            @(posedge clk); #1;
            if (overrun) begin ov_n++; ov_at = k; end
            if (motion_valid) begin
                v_n++; v_at = k;
                cap_dx = int'(motion_dx); cap_dy = int'(motion_dy); cap_cnt = int'(match_count);
            end
        end
        pair_valid = 1'b0;
        pair_done  = 1'b0;
        n_checks++; if (ov_at !== 5 || ov_n !== 1) begin n_fails++; $display("FAIL overrun_pulse: got %0d pulses last at edge %0d, expected 1 at edge 5", ov_n, ov_at); end
        n_checks++; if (v_n !== 1 || v_at !== 18) begin n_fails++; $display("FAIL overrun_valid: got %0d pulses last at edge %0d, expected 1 at edge 18", v_n, v_at); end
        n_checks++; if (cap_dx !== 8) begin n_fails++; $display("FAIL overrun_first_dx: got %0d expected 8", cap_dx); end
        n_checks++; if (cap_dy !== 10) begin n_fails++; $display("FAIL overrun_first_dy: got %0d expected 10", cap_dy); end
        n_checks++; if (cap_cnt !== 2) begin n_fails++; $display("FAIL overrun_first_count: got %0d expected 2", cap_cnt); end
        close_frame(1'b0, 0, 0, 0, 0, lat, busy_n, pulses, ov_n);
        n_checks++; if (int'(motion_dx) !== 2) begin n_fails++; $display("FAIL overrun_next_dx: got %0d expected 2", motion_dx); end
        n_checks++; if (int'(motion_dy) !== -1) begin n_fails++; $display("FAIL overrun_next_dy: got %0d expected -1", motion_dy); end
        n_checks++; if (int'(match_count) !== 2) begin n_fails++; $display("FAIL overrun_next_count: got %0d expected 2", match_count); end
    endtask

    task automatic test_reset_mid_divide();
        int lat, busy_n, pulses, ov_n, v_n;
        v_n = 0;
        drive_pair(109, 30, 100, 30);
        drive_pair(109, 30, 100, 30);
        pair_done = 1'b1;
        @(posedge clk); #1;
        pair_done = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        reset = 1'b0;
        #1;
        n_checks++; if (int'(motion_dx) !== 0) begin n_fails++; $display("FAIL midreset_dx: got %0d expected 0", motion_dx); end
        n_checks++; if (int'(motion_dy) !== 0) begin n_fails++; $display("FAIL midreset_dy: got %0d expected 0", motion_dy); end
        n_checks++; if (int'(match_count) !== 0) begin n_fails++; $display("FAIL midreset_count: got %0d expected 0", match_count); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (motion_valid) v_n++;
        end
        n_checks++; if (v_n !== 0) begin n_fails++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", v_n); end
        drive_pair(106, 30, 100, 30);
        drive_pair(106, 30, 100, 30);
        close_frame(1'b0, 0, 0, 0, 0, lat, busy_n, pulses, ov_n);
        n_checks++; if (pulses !== 1) begin n_fails++; $display("FAIL midreset_next_pulses: got %0d expected 1", pulses); end
        n_checks++; if (int'(motion_dx) !== 6) begin n_fails++; $display("FAIL midreset_next_dx: got %0d expected 6", motion_dx); end
        n_checks++; if (int'(match_count) !== 2) begin n_fails++; $display("FAIL midreset_next_count: got %0d expected 2", match_count); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_coincident();
        test_empty();
        test_max_pairs();
        test_overrun();
        test_reset_mid_divide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
